// File: rtl/gb_frame_capture_if.sv
// PPU pixel stream in, framebuffer write port out.
// The capture block is the slave. The PPU/RAM side is the master.
`timescale 1ns/1ps
interface gb_frame_capture_if #(
  parameter int ADDR_W = 14
);
  logic              ppu_vs;
  logic              ppu_hs;
  logic              ppu_de;
  logic [1:0]        ppu_color;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output ppu_vs, ppu_hs, ppu_de, ppu_color,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  ppu_vs, ppu_hs, ppu_de, ppu_color,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/gb_frame_capture.sv
// Captures the PPU pixel stream, packs four 2-bpp pixels per byte, and writes them into the
// back half of a double-buffered framebuffer. Buffers swap after each well-formed frame.
`timescale 1ns/1ps
module gb_frame_capture #(
  parameter int H_PIX  = 160,
  parameter int V_PIX  = 144,
  parameter int ADDR_W = 14
) (
  input  logic               tclk,
  input  logic               nrst,
  gb_frame_capture_if.slave  bus,
  output logic               front_buf,
  output logic               frame_toggle,
  output logic               sync_err
);

  localparam int XW  = $clog2(H_PIX + 1);
  localparam int YW  = $clog2(V_PIX + 1);
  localparam int BPL = H_PIX / 4;
  localparam logic [XW-1:0]     X_END     = XW'(H_PIX);
  localparam logic [YW-1:0]     Y_END     = YW'(V_PIX);
  localparam logic [ADDR_W-1:0] BPL_A     = ADDR_W'(BPL);
  localparam logic [ADDR_W-1:0] BUF_BYTES = ADDR_W'(BPL * V_PIX);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic              vs_q, hs_q, de_q, vsPrev_q, hsPrev_q;
  logic [1:0]        color_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [7:0]        pack_q, pack_d;
  logic              syncErr_d, front_d, toggle_d, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_d, byteAddr, lineOff, bufBase;
  logic [7:0]        wrData_d;
  logic              vsRise, hsRise;

  assign vsRise = vs_q & ~vsPrev_q;
  assign hsRise = hs_q & ~hsPrev_q;

  // The multiply by the constant BPL reduces to shift-add; for BPL=40 that is y*32 + y*8.
  assign lineOff  = ADDR_W'(y_q) * BPL_A;
  assign bufBase  = front_buf ? '0 : BUF_BYTES;
  assign byteAddr = bufBase + lineOff + ADDR_W'(x_q >> 2);

  // Same-cycle events resolve in the order pixel, then hsync, then vsync.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pack_d    = pack_q;
    syncErr_d = sync_err;
    front_d   = front_buf;
    toggle_d  = frame_toggle;
    wrEn_d    = 1'b0;
    wrAddr_d  = bus.wr_addr;
    wrData_d  = bus.wr_data;
    case (state_q)
      SYNC: begin
        if (vsRise) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ACTIVE: begin
        if (de_q) begin
          if (x_q < X_END && y_q < Y_END) begin
            pack_d[{x_q[1:0], 1'b0} +: 2] = color_q;
            if (x_q[1:0] == 2'd3) begin
              wrEn_d   = 1'b1;
              wrAddr_d = byteAddr;
              wrData_d = pack_d;
            end
            x_d = x_q + XW'(1);
          end else begin
            syncErr_d = 1'b1;
          end
        end
        if (hsRise) begin
          if (x_d != X_END) syncErr_d = 1'b1;
          x_d    = '0;
          if (y_d != Y_END) y_d = y_d + YW'(1);
          pack_d = '0;
        end
        if (vsRise) begin
          if (y_d == Y_END && x_d == '0) begin
            front_d  = ~front_buf;
            toggle_d = ~frame_toggle;
          end else begin
            syncErr_d = 1'b1;
          end
          x_d = '0;
          y_d = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge tclk) begin
    if (!nrst) begin
      state_q      <= SYNC;
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      color_q      <= '0;
      vsPrev_q     <= 1'b0;
      hsPrev_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      pack_q       <= '0;
      sync_err     <= 1'b0;
      front_buf    <= 1'b0;
      frame_toggle <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= bus.ppu_vs;
      hs_q         <= bus.ppu_hs;
      de_q         <= bus.ppu_de;
      color_q      <= bus.ppu_color;
      vsPrev_q     <= vs_q;
      hsPrev_q     <= hs_q;
      x_q          <= x_d;
      y_q          <= y_d;
      pack_q       <= pack_d;
      sync_err     <= syncErr_d;
      front_buf    <= front_d;
      frame_toggle <= toggle_d;
      bus.wr_en    <= wrEn_d;
      bus.wr_addr  <= wrAddr_d;
      bus.wr_data  <= wrData_d;
    end
  end

endmodule
